// File: rtl/core_seq_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencer.
// The opcode constants match the ones the control unit decodes.
package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_FAULT
    } seq_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_ILLEGAL  = 2'd1,
        CAUSE_TIMEOUT  = 2'd2,
        CAUSE_MISALIGN = 2'd3
    } fault_cause_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int NUM_OPCODES = 9;
    localparam logic [NUM_OPCODES-1:0][6:0] RV32I_OPCODES = {
        OPC_OP, OPC_OP_IMM, OPC_STORE, OPC_LOAD, OPC_BRANCH,
        OPC_JALR, OPC_JAL, OPC_AUIPC, OPC_LUI
    };

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    function automatic logic is_mem_opcode(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Bus-wait watchdog: counts consecutive waiting cycles and flags the last allowed one.
// TIMEOUT of 0 disables expiry entirely.
module seq_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic waiting,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count_reg <= '0;
        end else if (waiting) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && waiting && (count_reg == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I sequencer: owns PC/IR, steps FETCH..WB, gates RF writes to WB
// and raises a sticky fault on illegal opcode, bus timeout or misaligned next PC.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          TIMEOUT   = 16,
    parameter int          INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          instruction,
    output logic [31:0]          pc,
    input  logic [31:0]          next_pc,
    input  logic                 cu_rf_wen,
    input  logic                 cu_dm_wen,
    output logic                 rf_wen,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    input  logic                 halt_req,
    output logic                 halted,
    output logic                 fault,
    output logic [1:0]           fault_cause,
    output logic [INSTRET_W-1:0] instret
);

    seq_state_t           state_reg, state_next;
    fault_cause_t         cause_reg, cause_next;
    logic [31:0]          pc_reg;
    logic [31:0]          ir_reg;
    logic [INSTRET_W-1:0] instret_reg;

    logic [NUM_OPCODES-1:0] opc_hit;
    logic                   opc_legal;
    logic                   pc_aligned;
    logic                   waiting;
    logic                   wd_clr;
    logic                   wd_expired;
    logic                   retire;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPCODES; gi++) begin : g_opc
            assign opc_hit[gi] = (ir_reg[6:0] == RV32I_OPCODES[gi]);
        end
    endgenerate

    assign opc_legal  = |opc_hit;
    assign pc_aligned = (next_pc[1:0] == 2'b00);
    assign waiting    = ((state_reg == ST_FETCH) && !imem_ack) ||
                        ((state_reg == ST_MEM)   && !dmem_ack);
    // Any state change restarts the wait count, so each access gets a fresh budget.
    assign wd_clr     = (state_next != state_reg);

    seq_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .waiting (waiting),
        .expired (wd_expired)
    );

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        retire     = 1'b0;
        case (state_reg)
            ST_RESET:  state_next = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    state_next = ST_DECODE;
                end else if (wd_expired) begin
                    state_next = ST_FAULT;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (!opc_legal) begin
                    state_next = ST_FAULT;
                    cause_next = CAUSE_ILLEGAL;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC:   state_next = is_mem_opcode(ir_reg[6:0]) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_ack) begin
                    state_next = ST_WB;
                end else if (wd_expired) begin
                    state_next = ST_FAULT;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_WB: begin
                if (!pc_aligned) begin
                    state_next = ST_FAULT;
                    cause_next = CAUSE_MISALIGN;
                end else begin
                    retire     = 1'b1;
                    state_next = halt_req ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT:   if (!halt_req) state_next = ST_FETCH;
            ST_FAULT:  state_next = ST_FAULT;
            default:   state_next = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_RESET;
            cause_reg   <= CAUSE_NONE;
            pc_reg      <= RESET_PC;
            ir_reg      <= NOP_INSN;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            if ((state_reg == ST_FETCH) && imem_ack) begin
                ir_reg <= imem_rdata;
            end
            if (retire) begin
                pc_reg      <= next_pc;
                instret_reg <= instret_reg + 1'b1;
            end
        end
    end

    assign imem_req    = (state_reg == ST_FETCH);
    assign imem_addr   = pc_reg;
    assign instruction = ir_reg;
    assign pc          = pc_reg;
    assign rf_wen      = retire && cu_rf_wen;
    assign dmem_req    = (state_reg == ST_MEM);
    assign dmem_we     = (state_reg == ST_MEM) && cu_dm_wen;
    assign halted      = (state_reg == ST_HALT);
    assign fault       = (state_reg == ST_FAULT);
    assign fault_cause = cause_reg;
    assign instret     = instret_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: table of instructions driven through a bus responder,
// expected outcomes queued at drive time and compared when each instruction completes.
module tb_core_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 4;
    localparam int          BUDGET   = 40;
    localparam int          NVEC     = 11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        cu_rf_wen;
    logic        cu_dm_wen;
    logic        rf_wen;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        halt_req;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] instret;

    core_sequencer #(
        .RESET_PC  (RESET_PC),
        .TIMEOUT   (TIMEOUT),
        .INSTRET_W (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc          (pc),
        .next_pc     (next_pc),
        .cu_rf_wen   (cu_rf_wen),
        .cu_dm_wen   (cu_dm_wen),
        .rf_wen      (rf_wen),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .halt_req    (halt_req),
        .halted      (halted),
        .fault       (fault),
        .fault_cause (fault_cause),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int iw;          // imem cycles without ack before the ack
        int dw;          // dmem cycles without ack before the ack
        int rf;
        int dm;
        int halt;
        int pre_reset;
        int next_off;
        int exp_cycles;
        int exp_rf;
        int exp_dmem;
        int exp_we;
        int exp_fault;
        int exp_cause;
        int exp_halted;
    } vec_t;

    typedef struct {
        logic [31:0] cycles;
        logic [31:0] rf;
        logic [31:0] dmem;
        logic [31:0] we;
        logic [31:0] fault;
        logic [31:0] cause;
        logic [31:0] halted;
        logic [31:0] pc;
        logic [31:0] instret;
        logic [31:0] ir;
    } res_t;

    vec_t        vecs [NVEC];
    res_t        sb_q [$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] pc_model;
    logic [31:0] instret_model;
    logic [31:0] ir_model;

    function automatic vec_t mk_vec(input logic [31:0] instr, input int iw, input int dw,
                                    input int rf, input int dm, input int halt, input int pre_reset,
                                    input int next_off, input int exp_cycles, input int exp_rf,
                                    input int exp_dmem, input int exp_we, input int exp_fault,
                                    input int exp_cause, input int exp_halted);
        vec_t v;
        v.instr = instr;           v.iw = iw;                 v.dw = dw;
        v.rf = rf;                 v.dm = dm;                 v.halt = halt;
        v.pre_reset = pre_reset;   v.next_off = next_off;     v.exp_cycles = exp_cycles;
        v.exp_rf = exp_rf;         v.exp_dmem = exp_dmem;     v.exp_we = exp_we;
        v.exp_fault = exp_fault;   v.exp_cause = exp_cause;   v.exp_halted = exp_halted;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit full);
        @(negedge clk);
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        dmem_ack   = 1'b0;
        halt_req   = 1'b0;
        imem_rdata = 32'h0;
        cu_rf_wen  = 1'b0;
        cu_dm_wen  = 1'b0;
        next_pc    = 32'h0;
        repeat (3) @(negedge clk);
        pc_model      = RESET_PC;
        instret_model = 32'd0;
        ir_model      = 32'h0000_0013;
        if (full) begin
            check("rst_pc", pc, RESET_PC);
            check("rst_ir", instruction, 32'h0000_0013);
            check("rst_instret", instret, 32'd0);
            check("rst_imem_req", {31'd0, imem_req}, 32'd0);
            check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
            check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
            check("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
            check("rst_halted", {31'd0, halted}, 32'd0);
            check("rst_fault", {31'd0, fault}, 32'd0);
            check("rst_cause", {30'd0, fault_cause}, 32'd0);
        end
        rst_n = 1'b1;
        if (full) check("release_no_fetch_yet", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        if (full) check("fetch_after_release", {31'd0, imem_req}, 32'd1);
    endtask

    // Runs one instruction from a FETCH-state negedge until the next fetch, halt or fault.
    task automatic exec_vec(input int idx);
        vec_t v;
        res_t e;
        res_t r;
        int   iw;
        int   dw;
        bit   fetched;
        bit   seen_mem;
        bit   done;
        v = vecs[idx];
        iw = 0; dw = 0; fetched = 1'b0; seen_mem = 1'b0; done = 1'b0;
        if (v.pre_reset != 0) do_reset(1'b0);

        e.cycles  = v.exp_cycles;
        e.rf      = v.exp_rf;
        e.dmem    = v.exp_dmem;
        e.we      = v.exp_we;
        e.fault   = v.exp_fault;
        e.cause   = v.exp_cause;
        e.halted  = v.exp_halted;
        e.pc      = (v.exp_fault != 0) ? pc_model : pc_model + v.next_off;
        e.instret = (v.exp_fault != 0) ? instret_model : instret_model + 1;
        e.ir      = (v.exp_cause == 2) ? ir_model : v.instr;
        sb_q.push_back(e);

        cu_rf_wen = v.rf[0];
        cu_dm_wen = v.dm[0];
        next_pc   = pc_model + v.next_off;
        r.cycles = 0; r.rf = 0; r.dmem = 0; r.we = 0;

        for (int c = 0; c < BUDGET; c++) begin
            if (halted || fault || (imem_req && fetched)) begin
                done = 1'b1;
                break;
            end
            r.cycles++;
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (rf_wen) r.rf++;
            if (imem_req) begin
                if (iw == v.iw) begin
                    imem_ack   = 1'b1;
                    imem_rdata = v.instr;
                    fetched    = 1'b1;
                end else begin
                    iw++;
                end
            end
            if (dmem_req) begin
                r.dmem++;
                if (dmem_we) r.we++;
                seen_mem = 1'b1;
                if (dw == v.dw) dmem_ack = 1'b1;
                else dw++;
            end
            if (seen_mem && v.halt != 0) halt_req = 1'b1;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        check($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);

        r.fault   = {31'd0, fault};
        r.cause   = {30'd0, fault_cause};
        r.halted  = {31'd0, halted};
        r.pc      = pc;
        r.instret = instret;
        r.ir      = instruction;

        e = sb_q.pop_front();
        check($sformatf("v%0d_cycles", idx),  r.cycles,  e.cycles);
        check($sformatf("v%0d_rf_wen", idx),  r.rf,      e.rf);
        check($sformatf("v%0d_dmem", idx),    r.dmem,    e.dmem);
        check($sformatf("v%0d_dmem_we", idx), r.we,      e.we);
        check($sformatf("v%0d_fault", idx),   r.fault,   e.fault);
        check($sformatf("v%0d_cause", idx),   r.cause,   e.cause);
        check($sformatf("v%0d_halted", idx),  r.halted,  e.halted);
        check($sformatf("v%0d_pc", idx),      r.pc,      e.pc);
        check($sformatf("v%0d_instret", idx), r.instret, e.instret);
        check($sformatf("v%0d_ir", idx),      r.ir,      e.ir);
        pc_model      = e.pc;
        instret_model = e.instret;
        ir_model      = e.ir;
        $display("vec %0d insn=%08h cycles=%0d rf=%0d dmem=%0d fault=%0d cause=%0d pc=%08h instret=%0d",
                 idx, v.instr, r.cycles, r.rf, r.dmem, r.fault, r.cause, r.pc, r.instret);
    endtask

    initial begin
        bit got_mem;
        //                 instr          iw  dw rf dm ht rs off cyc rf dm we  f cause hlt
        vecs[0]  = mk_vec(32'h00500093,  0,  0, 1, 0, 0, 0, 4,  4, 1, 0, 0, 0, 0, 0); // ADDI
        vecs[1]  = mk_vec(32'h0020A023,  0,  2, 0, 1, 0, 0, 4,  7, 0, 3, 3, 0, 0, 0); // SW, slow ack
        vecs[2]  = mk_vec(32'h0000A183,  1,  0, 1, 0, 0, 0, 4,  6, 1, 1, 0, 0, 0, 0); // LW
        vecs[3]  = mk_vec(32'h002081B3,  2,  0, 1, 0, 0, 0, 4,  6, 1, 0, 0, 0, 0, 0); // ADD
        vecs[4]  = mk_vec(32'h00208463,  0,  0, 0, 0, 0, 0, 8,  4, 0, 0, 0, 0, 0, 0); // BEQ taken
        vecs[5]  = mk_vec(32'h0080006F,  0,  0, 1, 0, 0, 0, 8,  4, 1, 0, 0, 0, 0, 0); // JAL
        vecs[6]  = mk_vec(32'h00500093,  3,  0, 1, 0, 0, 0, 4,  7, 1, 0, 0, 0, 0, 0); // ack in expiry cycle
        vecs[7]  = mk_vec(32'h00500093, 99,  0, 1, 0, 0, 0, 4,  4, 0, 0, 0, 1, 2, 0); // fetch timeout
        vecs[8]  = mk_vec(32'hFFFFFFFF,  0,  0, 1, 0, 0, 1, 4,  2, 0, 0, 0, 1, 1, 0); // illegal
        vecs[9]  = mk_vec(32'h00500093,  0,  0, 1, 0, 0, 1, 6,  4, 0, 0, 0, 1, 3, 0); // misaligned
        vecs[10] = mk_vec(32'h0020A023,  0,  1, 0, 1, 1, 1, 4,  6, 0, 2, 2, 0, 0, 1); // halt in MEM

        do_reset(1'b1);
        for (int i = 0; i < NVEC; i++) begin
            exec_vec(i);
        end

        // Halt persists while requested, then resumes fetching at the retired PC.
        repeat (2) @(negedge clk);
        check("halt_hold", {31'd0, halted}, 32'd1);
        check("halt_no_fetch", {31'd0, imem_req}, 32'd0);
        halt_req = 1'b0;
        @(negedge clk);
        check("resume_fetch", {31'd0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, pc_model);
        check("resume_halted_clear", {31'd0, halted}, 32'd0);
        exec_vec(0);

        // Reset during a load drops the data request and skips the write-back.
        cu_rf_wen = 1'b1;
        cu_dm_wen = 1'b0;
        next_pc   = pc_model + 4;
        got_mem   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            imem_ack = 1'b0;
            if (dmem_req) begin
                got_mem = 1'b1;
                break;
            end
            if (imem_req) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'h0000A183;
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        check("midmem_reached", {31'd0, got_mem}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midmem_dmem_req_drop", {31'd0, dmem_req}, 32'd0);
        check("midmem_rf_wen", {31'd0, rf_wen}, 32'd0);
        check("midmem_instret", instret, 32'd0);
        check("midmem_pc", pc, RESET_PC);
        rst_n = 1'b1;
        @(negedge clk);
        check("midmem_refetch", {31'd0, imem_req}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected completion");
        $fatal(1, "bench time limit reached");
    end

endmodule
